// File: rtl/mips_mem_sequencer_if.sv
// Shared single-ported memory bus between the MIPS sequencer (master) and
// the variable-latency memory (slave). Read data is valid in the ack cycle.
interface mips_mem_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_byte,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_byte,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mips_mem_sequencer.sv
// Multi-cycle sequencer for the MIPS datapath: fetches an instruction over the
// shared memory bus, lets the decoder settle, runs the optional data access and
// pulses a one-cycle commit. A decode exception or an unanswered request halts
// the sequencer until reset.
module mips_mem_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 pc,
    input  logic [31:0]                 data_addr,
    input  logic [31:0]                 store_data,
    input  logic                        mem_read,
    input  logic                        word_we,
    input  logic                        byte_we,
    input  logic                        byte_load,
    input  logic                        except,
    mips_mem_sequencer_if.master        mem,
    output logic [31:0]                 inst,
    output logic [31:0]                 load_data,
    output logic                        commit,
    output logic                        halted,
    output logic                        bus_error
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DATA,
        S_COMMIT,
        S_HALT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             req;
    logic             wr;
    logic             byte_sz;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             set_halt;
    logic             set_berr;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             timed_out;

    // The count is what it will be after this unanswered cycle; hitting the
    // limit means this is the last request cycle allowed.
    assign wait_cnt_inc = wait_cnt + 1'b1;
    assign timed_out    = (wait_cnt_inc == CNT_LIMIT);

    assign mem.mem_req   = req;
    assign mem.mem_we    = wr;
    assign mem.mem_byte  = byte_sz;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata;

    // State register; reset drops the request asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore bus/commit outputs; an ack wins over a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        wr        = 1'b0;
        byte_sz   = 1'b0;
        addr      = '0;
        wdata     = '0;
        commit    = 1'b0;
        set_halt  = 1'b0;
        set_berr  = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                req  = 1'b1;
                addr = pc;
                if (mem.mem_ack) begin
                    state_nxt = S_DECODE;
                end else if (timed_out) begin
                    state_nxt = S_HALT;
                    set_halt  = 1'b1;
                    set_berr  = 1'b1;
                end
            end
            S_DECODE: begin
                if (except) begin
                    state_nxt = S_HALT;
                    set_halt  = 1'b1;
                end else if (mem_read || word_we || byte_we) begin
                    state_nxt = S_DATA;
                end else begin
                    state_nxt = S_COMMIT;
                end
            end
            S_DATA: begin
                req     = 1'b1;
                addr    = data_addr;
                wr      = word_we | byte_we;
                byte_sz = byte_we | byte_load;
                wdata   = (word_we | byte_we) ? store_data : '0;
                if (mem.mem_ack) begin
                    state_nxt = S_COMMIT;
                end else if (timed_out) begin
                    state_nxt = S_HALT;
                    set_halt  = 1'b1;
                    set_berr  = 1'b1;
                end
            end
            S_COMMIT: begin
                commit    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Wait counter: runs only while a request is outstanding, otherwise held at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (req && !mem.mem_ack) begin
            wait_cnt <= wait_cnt_inc;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Capture fetched instruction and read data in the ack cycle; writes keep load_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst      <= '0;
            load_data <= '0;
        end else begin
            if (state == S_FETCH && mem.mem_ack) begin
                inst <= mem.mem_rdata;
            end
            if (state == S_DATA && mem.mem_ack && !wr) begin
                load_data <= mem.mem_rdata;
            end
        end
    end

    // Sticky halt flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted    <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            if (set_halt) begin
                halted <= 1'b1;
            end
            if (set_berr) begin
                bus_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Bench for mips_mem_sequencer: directed instruction sequences against a
// transaction-level model of the fetch/decode/data/commit flow.
module tb_mips_mem_sequencer;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] store_data = '0;
    logic        mem_read = 1'b0;
    logic        word_we = 1'b0;
    logic        byte_we = 1'b0;
    logic        byte_load = 1'b0;
    logic        except = 1'b0;
    logic [31:0] inst;
    logic [31:0] load_data;
    logic        commit;
    logic        halted;
    logic        bus_error;

    mips_mem_sequencer_if mbus ();

    mips_mem_sequencer #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .data_addr  (data_addr),
        .store_data (store_data),
        .mem_read   (mem_read),
        .word_we    (word_we),
        .byte_we    (byte_we),
        .byte_load  (byte_load),
        .except     (except),
        .mem        (mbus.master),
        .inst       (inst),
        .load_data  (load_data),
        .commit     (commit),
        .halted     (halted),
        .bus_error  (bus_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Memory contents seen by the bench's responder.
    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        if (a == 32'h0000_0000) return 32'h0085_1021;
        return a ^ 32'h8C00_0000;
    endfunction

    // Memory responder: acks after a per-address delay, or never when disabled.
    bit          ack_en = 1'b1;
    int          ack_delay = 0;
    logic [31:0] slow_addr = '1;
    int          slow_delay = 0;
    bit          force_ack = 1'b0;
    int          req_cyc = 0;
    int          cur_delay = 0;

    initial begin
        mbus.mem_ack   = 1'b0;
        mbus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                mbus.mem_ack   = 1'b1;
                mbus.mem_rdata = 32'h5A5A_5A5A;
                req_cyc        = 0;
            end else if (mbus.mem_req && ack_en && reset) begin
                req_cyc++;
                cur_delay      = (mbus.mem_addr == slow_addr) ? slow_delay : ack_delay;
                mbus.mem_ack   = (req_cyc > cur_delay);
                mbus.mem_rdata = memval(mbus.mem_addr);
            end else begin
                req_cyc        = 0;
                mbus.mem_ack   = 1'b0;
                mbus.mem_rdata = '0;
            end
        end
    end

    // Expected outputs produced by the model.
    logic        e_req, e_we, e_byte, e_commit, e_halted, e_berr;
    logic [31:0] e_addr, e_wdata, e_inst, e_ld;

    task automatic exp_quiet();
        e_req    = 1'b0;
        e_we     = 1'b0;
        e_byte   = 1'b0;
        e_addr   = '0;
        e_wdata  = '0;
        e_commit = 1'b0;
    endtask

    task automatic exp_reset();
        exp_quiet();
        e_inst   = '0;
        e_ld     = '0;
        e_halted = 1'b0;
        e_berr   = 1'b0;
    endtask

    // One bus access: outcome 0 = acked (rd valid), 1 = timed out, 2 = reset.
    task automatic model_access(output int outcome, output logic [31:0] rd);
        int n;
        n       = 0;
        outcome = 0;
        rd      = '0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                outcome = 2;
                return;
            end
            n++;
            if (mbus.mem_ack) begin
                rd = mbus.mem_rdata;
                return;
            end
            if (n >= TO) begin
                outcome = 1;
                return;
            end
        end
    endtask

    // Instruction-level behaviour from reset release until the next reset.
    task automatic model_run();
        int          oc;
        logic [31:0] rd;
        bit          wr;
        @(posedge clk or negedge reset);
        if (!reset) return;
        forever begin
            exp_quiet();
            e_req  = 1'b1;
            e_addr = pc;
            model_access(oc, rd);
            if (oc == 2) return;
            if (oc == 1) begin
                exp_quiet();
                e_halted = 1'b1;
                e_berr   = 1'b1;
                @(negedge reset);
                return;
            end
            e_inst = rd;
            exp_quiet();
            @(posedge clk or negedge reset);
            if (!reset) return;
            if (except) begin
                e_halted = 1'b1;
                @(negedge reset);
                return;
            end
            if (mem_read || word_we || byte_we) begin
                wr      = word_we | byte_we;
                e_req   = 1'b1;
                e_addr  = data_addr;
                e_we    = wr;
                e_byte  = byte_we | byte_load;
                e_wdata = wr ? store_data : 32'h0;
                model_access(oc, rd);
                if (oc == 2) return;
                if (oc == 1) begin
                    exp_quiet();
                    e_halted = 1'b1;
                    e_berr   = 1'b1;
                    @(negedge reset);
                    return;
                end
                if (!wr) e_ld = rd;
                exp_quiet();
            end
            e_commit = 1'b1;
            @(posedge clk or negedge reset);
            if (!reset) return;
        end
    endtask

    initial begin
        exp_reset();
        wait (reset === 1'b0);
        forever begin
            exp_reset();
            wait (reset === 1'b1);
            model_run();
        end
    end

    // Cycle compare of every output against the model.
    initial begin
        wait (chk_en);
        forever begin
            @(negedge clk);
            chk("mem_req",   32'(mbus.mem_req),  32'(e_req));
            chk("mem_we",    32'(mbus.mem_we),   32'(e_we));
            chk("mem_byte",  32'(mbus.mem_byte), 32'(e_byte));
            chk("mem_addr",  mbus.mem_addr,      e_addr);
            chk("mem_wdata", mbus.mem_wdata,     e_wdata);
            chk("inst",      inst,               e_inst);
            chk("load_data", load_data,          e_ld);
            chk("commit",    32'(commit),        32'(e_commit));
            chk("halted",    32'(halted),        32'(e_halted));
            chk("bus_error", 32'(bus_error),     32'(e_berr));
        end
    end

    // Observations gathered while an instruction runs.
    int          req_da;
    int          req_all;
    bit          seen_we;
    bit          seen_byte;
    logic [31:0] seen_wdata;

    task automatic run_instr(input bit rd, input bit wwe, input bit bwe, input bit bld,
                             input bit exc, input logic [31:0] da, input logic [31:0] sd,
                             output bit committed);
        int cyc;
        mem_read   = rd;
        word_we    = wwe;
        byte_we    = bwe;
        byte_load  = bld;
        except     = exc;
        data_addr  = da;
        store_data = sd;
        cyc        = 0;
        committed  = 1'b0;
        req_da     = 0;
        req_all    = 0;
        seen_we    = 1'b0;
        seen_byte  = 1'b0;
        seen_wdata = '0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mbus.mem_req) req_all++;
            if (mbus.mem_req && mbus.mem_addr == da && (rd || wwe || bwe)) req_da++;
            if (mbus.mem_req && mbus.mem_we) begin
                seen_we    = 1'b1;
                seen_byte  = mbus.mem_byte;
                seen_wdata = mbus.mem_wdata;
            end
            if (commit) begin
                committed = 1'b1;
                pc        = pc + 32'd4;
                break;
            end
            if (halted) break;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    bit ok;
    int cnt;
    int found;

    initial begin
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;

        // Test 1: reset for 3 cycles, then an addu with immediate acks.
        repeat (3) @(negedge clk);
        chk("t1_reset_req", 32'(mbus.mem_req), 32'd0);
        chk("t1_reset_inst", inst, 32'd0);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("t1_req_rise", 32'(mbus.mem_req), 32'd1);
        chk("t1_fetch_addr", mbus.mem_addr, 32'd0);
        @(negedge clk);
        chk("t1_decode_noreq", 32'(mbus.mem_req), 32'd0);
        chk("t1_inst", inst, 32'h0085_1021);
        @(negedge clk);
        chk("t1_commit_cycle3", 32'(commit), 32'd1);
        pc = 32'd4;
        @(negedge clk);
        chk("t1_next_fetch", mbus.mem_addr, 32'd4);

        // Test 2: lw from 0x100, data ack delayed by 2 cycles.
        slow_addr  = 32'h100;
        slow_delay = 2;
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, ok);
        chk("t2_commit", 32'(ok), 32'd1);
        chk("t2_addr_held", 32'(req_da), 32'd3);
        chk("t2_load_data", load_data, 32'hDEAD_BEEF);
        slow_addr = '1;

        // Test 5b: fetch acked on its 4th request cycle completes normally.
        ack_delay = 3;
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ok);
        ack_delay = 0;
        chk("t5b_commit", 32'(ok), 32'd1);
        chk("t5b_req_cycles", 32'(req_all), 32'd4);
        chk("t5b_no_error", 32'(halted), 32'd0);

        // Test 3: sb to 0x203.
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h203, 32'h0000_00A5, ok);
        chk("t3_commit", 32'(ok), 32'd1);
        chk("t3_we_seen", 32'(seen_we), 32'd1);
        chk("t3_byte", 32'(seen_byte), 32'd1);
        chk("t3_wdata", seen_wdata, 32'h0000_00A5);
        chk("t3_load_kept", load_data, 32'hDEAD_BEEF);

        // sw to 0x120: word-sized write.
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h120, 32'h1234_5678, ok);
        chk("sw_commit", 32'(ok), 32'd1);
        chk("sw_word", 32'(seen_byte), 32'd0);
        chk("sw_wdata", seen_wdata, 32'h1234_5678);

        // Test 4: decode exception halts with no bus error.
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, ok);
        except = 1'b0;
        chk("t4_no_commit", 32'(ok), 32'd0);
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_bus_error", 32'(bus_error), 32'd0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (mbus.mem_req || commit) cnt++;
        end
        chk("t4_quiet_after_halt", 32'(cnt), 32'd0);

        // Test 5a: no ack at all during fetch -> bus error after TO request cycles.
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        ack_en = 1'b0;
        pc     = 32'h40;
        #2 reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (halted) break;
            if (mbus.mem_req) cnt++;
        end
        chk("t5a_req_cycles", 32'(cnt), 32'd4);
        chk("t5a_halted", 32'(halted), 32'd1);
        chk("t5a_bus_error", 32'(bus_error), 32'd1);
        chk("t5a_no_inst", inst, 32'd0);

        // Recover and load a byte so load_data holds a non-zero value.
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        ack_en = 1'b1;
        pc     = 32'h80;
        #2 reset = 1'b1;
        run_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h155, 32'h0, ok);
        chk("lbu_commit", 32'(ok), 32'd1);
        chk("lbu_load", load_data, 32'h8C00_0155);
        chk("lbu_clears_error", 32'(bus_error), 32'd0);

        // Test 6: reset while a data read is pending.
        slow_addr  = 32'h300;
        slow_delay = 100;
        mem_read   = 1'b1;
        byte_load  = 1'b0;
        data_addr  = 32'h300;
        found      = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mbus.mem_req && mbus.mem_addr == 32'h300) begin
                found = 1;
                break;
            end
        end
        chk("t6_data_pending", 32'(found), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        force_ack = 1'b1;
        #1;
        chk("t6_req_async_drop", 32'(mbus.mem_req), 32'd0);
        chk("t6_inst_cleared", inst, 32'd0);
        chk("t6_load_cleared", load_data, 32'd0);
        repeat (2) @(negedge clk);
        chk("t6_ack_ignored", 32'(mbus.mem_req), 32'd0);
        force_ack  = 1'b0;
        mem_read   = 1'b0;
        slow_addr  = '1;
        pc         = 32'h400;
        #2 reset = 1'b1;
        @(negedge clk);
        chk("t6_restart_req", 32'(mbus.mem_req), 32'd1);
        chk("t6_restart_addr", mbus.mem_addr, 32'h400);
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ok);
        chk("t6_restart_commit", 32'(ok), 32'd1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
